// File: rtl/buzzer_ctl_mc.sv
// buzzer_ctl_mc: multi-channel square-wave tone generator.
//
// Each channel counts half-periods of (div_act + 1) cycles and toggles its
// amplitude at every boundary. The divisor and the mute request are latched only
// at a boundary, or while the channel is idle. This keeps every half-period whole
// when the inputs change, so a tone never produces a short pulse.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         global enable; when low, all state and outputs hold and tick stays 0
//   note_div   per-channel divisor, channel i at [i*CNT_W +: CNT_W]; 0 = silent
//   vol_pos    sample emitted while the amplitude is high (shared by all channels)
//   vol_neg    sample emitted while the amplitude is low (shared by all channels)
//   mute       per-channel mute request
//   audio_out  per-channel registered sample, channel i at [i*VOL_W +: VOL_W]
//   tick       per-channel registered pulse on each low->high amplitude edge
module buzzer_ctl_mc #(
  parameter int NCH   = 2,
  parameter int CNT_W = 22,
  parameter int VOL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH*CNT_W-1:0] note_div,
  input  logic [VOL_W-1:0]     vol_pos,
  input  logic [VOL_W-1:0]     vol_neg,
  input  logic [NCH-1:0]       mute,
  output logic [NCH*VOL_W-1:0] audio_out,
  output logic [NCH-1:0]       tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             ampli_q, ampli_d;
    logic             mute_q, mute_d;
    logic             tick_q, tick_d;
    logic [VOL_W-1:0] audio_q, audio_d;
    logic [CNT_W-1:0] div_in;

    assign div_in = note_div[i*CNT_W +: CNT_W];

    always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      ampli_d = ampli_q;
      mute_d  = mute_q;
      tick_d  = 1'b0;
      audio_d = audio_q;
      if (en) begin
        // The output follows the state held before this edge, which gives one cycle of latency.
        if (div_q == '0 || mute_q) begin
          audio_d = '0;
        end else begin
          audio_d = ampli_q ? vol_pos : vol_neg;
        end

        if (div_q == '0) begin
          // Idle: restart from low amplitude and accept new settings right away.
          cnt_d   = '0;
          ampli_d = 1'b0;
          div_d   = div_in;
          mute_d  = mute[i];
        end else if (cnt_q >= div_q) begin
          cnt_d   = '0;
          ampli_d = ~ampli_q;
          div_d   = div_in;
          mute_d  = mute[i];
          tick_d  = ~ampli_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        div_q   <= '0;
        ampli_q <= 1'b0;
        mute_q  <= 1'b1;
        tick_q  <= 1'b0;
        audio_q <= '0;
      end else begin
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        ampli_q <= ampli_d;
        mute_q  <= mute_d;
        tick_q  <= tick_d;
        audio_q <= audio_d;
      end
    end

    assign audio_out[i*VOL_W +: VOL_W] = audio_q;
    assign tick[i]                     = tick_q;
  end

endmodule

// File: tb/tb_buzzer_ctl_mc.sv
// tb_buzzer_ctl_mc: checks buzzer_ctl_mc with directed and randomized stimulus
// against a model that tracks how many enabled cycles remain in each half-period.
module tb_buzzer_ctl_mc;
  localparam int NCH   = 2;
  localparam int CNT_W = 22;
  localparam int VOL_W = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic [NCH*CNT_W-1:0] note_div = '0;
  logic [VOL_W-1:0]     vol_pos = '0;
  logic [VOL_W-1:0]     vol_neg = '0;
  logic [NCH-1:0]       mute = '0;
  logic [NCH*VOL_W-1:0] audio_out;
  logic [NCH-1:0]       tick;

  int checks = 0;
  int errors = 0;

  // Model state: whether a tone is running, the current level, the latched mute,
  // the enabled edges left before the next toggle, and the expected outputs.
  bit         m_run  [NCH];
  bit         m_lvl  [NCH];
  bit         m_mute [NCH];
  int         m_rem  [NCH];
  logic [VOL_W-1:0] e_audio [NCH];
  bit         e_tick [NCH];

  buzzer_ctl_mc #(.NCH(NCH), .CNT_W(CNT_W), .VOL_W(VOL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .note_div  (note_div),
    .vol_pos   (vol_pos),
    .vol_neg   (vol_neg),
    .mute      (mute),
    .audio_out (audio_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_lvl[i] = 0; m_mute[i] = 1; m_rem[i] = 0;
      e_audio[i] = '0; e_tick[i] = 0;
    end
  endtask

  // Advance the model by one clock edge, using the inputs in force before the edge.
  task automatic model_edge();
    int d;
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = 0;
      if (en) begin
        e_audio[i] = (!m_run[i] || m_mute[i]) ? '0 : (m_lvl[i] ? vol_pos : vol_neg);
        d = int'(note_div[i*CNT_W +: CNT_W]);
        if (!m_run[i]) begin
          m_lvl[i] = 0;
          m_run[i] = (d != 0); m_rem[i] = d + 1; m_mute[i] = mute[i];
        end else begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            e_tick[i] = !m_lvl[i];
            m_lvl[i]  = !m_lvl[i];
            m_run[i]  = (d != 0); m_rem[i] = d + 1; m_mute[i] = mute[i];
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("audio%0d", i), 64'(audio_out[i*VOL_W +: VOL_W]), 64'(e_audio[i]));
      check($sformatf("tick%0d", i), 64'(tick[i]), 64'(e_tick[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic set_div(input int ch, input int d);
    note_div[ch*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  initial begin
    int waited;
    model_reset();
    #1;
    check("reset_audio", 64'(audio_out), 64'd0);
    check("reset_tick", 64'(tick), 64'd0);
    @(negedge clk);
    rst = 0;

    // Basic tone: ch0 divisor 3 alternates 4 low and 4 high cycles; ch1 stays silent.
    en = 1; mute = '0; vol_pos = 16'h4000; vol_neg = 16'hC000;
    set_div(0, 3); set_div(1, 0);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k >= 2) begin
        check("tone_ch0", 64'(audio_out[15:0]),
              64'((((k - 2) / 4) % 2) ? 16'h4000 : 16'hC000));
        check("tone_tick0", 64'(tick[0]), 64'((k == 5 || k == 13) ? 1 : 0));
        check("tone_ch1", 64'(audio_out[31:16]), 64'd0);
        check("tone_tick1", 64'(tick[1]), 64'd0);
      end
    end

    // Divisor change in mid half-period.
    set_div(0, 1);
    repeat (12) step();

    // Mute requests in mid half-period.
    set_div(0, 3);
    repeat (6) step();
    mute[0] = 1;
    repeat (10) step();
    mute[0] = 0;
    repeat (10) step();

    // Freeze with the enable low, then resume.
    set_div(0, 5);
    repeat (15) step();
    en = 0;
    repeat (10) step();
    en = 1;
    repeat (15) step();

    // Start both channels together from idle; they must stay phase-locked.
    set_div(0, 0); set_div(1, 0);
    repeat (20) step();
    set_div(0, 2); set_div(1, 2);
    repeat (20) begin
      step();
      check("lock_audio", 64'(audio_out[31:16]), 64'(audio_out[15:0]));
      check("lock_tick", 64'(tick[1]), 64'(tick[0]));
    end

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 99) < 85);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 99) < 8) set_div(i, $urandom_range(0, 5));
        if ($urandom_range(0, 99) < 8) mute[i] = 1'($urandom_range(0, 1));
      end
      vol_pos = 16'($urandom);
      vol_neg = 16'($urandom);
      step();
    end

    // Reset while ch0 is high in mid half-period.
    en = 1; mute = '0; set_div(0, 4);
    waited = 0;
    while (!(m_run[0] && m_lvl[0] && m_rem[0] == 3) && waited < 200) begin
      step();
      waited++;
    end
    check("rst_wait_timeout", 64'(waited < 200), 64'd1);
    rst = 1;
    #1;
    model_reset();
    check("rst_audio", 64'(audio_out), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    @(negedge clk);
    rst = 0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
